jtcop_snd_latch: RTL and testbench
==================================

Name: jtcop_snd_latch

Overview:
- Main-CPU-to-sound-CPU command channel. Sits directly upstream of the sound CPU block and drives its `latch` and `snreq` inputs.
- Main CPU byte writes are queued in a small FIFO. Each byte is presented on `latch`, and a request is raised on `snreq`, whose rising edge triggers the sound CPU NMI.
- A sound-side read of the latch acknowledges the current byte and releases the next one after a programmable gap. Without the gap, back-to-back commands would be lost.

Parameters:
- AW, 2: FIFO address width; depth = 2**AW entries.
- GAP, 16: clk cycles `snreq` stays low between two successive requests; minimum 2.

Ports:
- clk  in  1  system clock, 24 MHz domain of the sound block
- rst_n  in  1  reset; synchronous, active-low
- main_we  in  1  main CPU write strobe to the sound-latch address; level, may stay high many cycles
- main_din  in  8  main CPU data, valid while `main_we` is high
- flush  in  1  synchronous clear of FIFO and request, e.g. on main-CPU soft reset
- snd_rd  in  1  sound-side latch read, i.e. `latch_cs`; level, may stay high many cycles
- latch  out  8  byte presented to the sound CPU
- snreq  out  1  request to the sound CPU
- pending  out  AW+1  number of queued bytes, including the one presented
- overrun  out  1  sticky flag: a write was dropped because the FIFO was full

Behaviour:
- Reset (`rst_n` low at a clk edge):
  - `latch`=8'h00, `snreq`=0, `pending`=0, `overrun`=0.
  - Read and write pointers = 0; state = IDLE; gap counter = 0.
- Write acceptance:
  - Rising edge of `main_we`, detected against a registered copy. Exactly one push per strobe, whatever its length.
  - `main_din` is sampled in the cycle the rising edge is detected.
  - FIFO full at that push → byte dropped, `overrun` set to 1. `overrun` clears only on reset or `flush`.
- Read acknowledge:
  - Rising edge of `snd_rd`, detected against a registered copy.
  - Counts only in state REQ; ignored in every other state.
- State machine:
  - IDLE: FIFO non-empty → next cycle `latch` loads head, `snreq`=1, go to REQ.
  - REQ:
    - `latch` and `snreq` are held stable.
    - On acknowledge: pop head, `snreq`=0, gap counter = GAP-1, go to GAP.
    - `latch` keeps its old value until the next load.
  - GAP:
    - Counter decrements each cycle.
    - When the counter is 0 and the FIFO is non-empty: load head, `snreq`=1, go to REQ.
    - When the counter is 0 and the FIFO is empty: go to IDLE.
- Latency:
  - Push into an empty FIFO in IDLE: `snreq` high 2 cycles after the `main_we` rising edge (1 cycle edge detect, 1 cycle load).
  - Acknowledge to next `snreq` rise: GAP+1 cycles.
- `pending`:
  - Push increments, pop decrements. Simultaneous push and pop in one cycle leaves it unchanged.
  - Push and pop in the same cycle with the FIFO full: the pop is processed first, so the push is accepted and `overrun` stays 0.
- Pointers wrap modulo 2**AW. Full/empty are derived from the AW+1 count, not from pointer equality.
- `flush` has priority over push, pop and state updates:
  - FIFO emptied, `snreq`=0, `overrun`=0, state = IDLE.
  - `latch` is unchanged.
  - A push in the same cycle as `flush` is discarded.
- Reset mid-request: `snreq` drops in the same cycle; no partial state survives.
- `snd_rd` held high across the GAP→REQ transition: no new acknowledge is generated. A fresh rising edge is required.

Decomposition:
- Shared package: none needed. AW and GAP are local parameters.
- One natural sub-module: `jtcop_snd_fifo`, a synchronous FIFO.
  - Parameterised AW, 8-bit data.
  - Ports: push/din, pop/dout, count, full, empty, clear.
  - Register array with async read of the head, so `latch` loads the same cycle the state machine decides.
- The top holds the edge detectors, the state machine, the gap counter and the `overrun` flag.

Test Plan:
- Single command: reset, then `main_we` high 5 cycles with din=8'h3A → `snreq` rises exactly 2 cycles after the strobe edge, `latch`=8'h3A, `pending`=1. `snd_rd` pulse → `snreq`=0 next cycle, `pending`=0, IDLE after GAP cycles.
- Burst: write 8'h11, 8'h22, 8'h33 back-to-back, acknowledge each → `latch` sequence 11, 22, 33. `snreq` low exactly GAP=16 cycles between requests. Three `snreq` rising edges total.
- Overrun, AW=2: write 5 bytes with no acknowledge → `pending`=4, `overrun`=1, fifth byte absent from the later read sequence.
- Long strobes: `main_we` held 100 cycles → exactly one push. `snd_rd` held high through GAP and the next REQ → second byte is not acknowledged until `snd_rd` falls and rises again.
- Full plus simultaneous push/pop: FIFO full in REQ, `main_we` edge and `snd_rd` edge in the same cycle → `pending` stays 4, `overrun` stays 0.
- Flush and reset: with 3 bytes queued, assert `flush` one cycle → `snreq`=0, `pending`=0, `overrun`=0, `latch` unchanged. Repeat with `rst_n` low one cycle → all outputs at their reset values including `latch`=8'h00.

Source files
------------

// File: rtl/jtcop_snd_fifo.sv
// Small synchronous command FIFO for the sound latch.
// The head byte is read combinationally, so the latch can load it in the same cycle the controller decides to.
module jtcop_snd_fifo #(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  localparam int DEPTH = 2 ** AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok, pop_ok;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst_n && !clear && push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/jtcop_snd_latch.sv
// Main-to-sound CPU command channel: queues main CPU writes and hands them to the
// sound CPU one at a time, with a guaranteed low gap on snreq between requests.
module jtcop_snd_latch #(
  parameter int AW  = 2,
  parameter int GAP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        main_we,
  input  logic [7:0]  main_din,
  input  logic        flush,
  input  logic        snd_rd,
  output logic [7:0]  latch,
  output logic        snreq,
  output logic [AW:0] pending,
  output logic        overrun
);
  localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    latch_reg, latch_next;
  logic          snreq_reg, snreq_next;
  logic          overrun_reg, overrun_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          we_reg, rd_reg;
  logic          we_rise, rd_rise;
  logic          push, pop, clear;
  logic [7:0]    head;
  logic          full, empty;

  assign we_rise = main_we & ~we_reg;
  assign rd_rise = snd_rd & ~rd_reg;

  jtcop_snd_fifo #(.AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (main_din),
    .pop   (pop),
    .dout  (head),
    .count (pending),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      latch_reg   <= 8'h00;
      snreq_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      rd_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      latch_reg   <= latch_next;
      snreq_reg   <= snreq_next;
      overrun_reg <= overrun_next;
      cnt_reg     <= cnt_next;
      we_reg      <= main_we;
      rd_reg      <= snd_rd;
    end
  end

  always_comb begin
    state_next   = state_reg;
    latch_next   = latch_reg;
    snreq_next   = snreq_reg;
    overrun_next = overrun_reg;
    cnt_next     = cnt_reg;
    push         = we_rise;
    pop          = 1'b0;
    clear        = 1'b0;
    if (flush) begin
      // latch deliberately keeps its value across a flush
      clear        = 1'b1;
      push         = 1'b0;
      state_next   = ST_IDLE;
      snreq_next   = 1'b0;
      overrun_next = 1'b0;
      cnt_next     = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!empty) begin
            latch_next = head;
            snreq_next = 1'b1;
            state_next = ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_rise) begin
            pop        = 1'b1;
            snreq_next = 1'b0;
            cnt_next   = CW'(GAP - 1);
            state_next = ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_reg == '0) begin
            if (!empty) begin
              latch_next = head;
              snreq_next = 1'b1;
              state_next = ST_REQ;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            cnt_next = cnt_reg - CW'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
      if (push && full && !pop) overrun_next = 1'b1;
    end
  end

  assign latch   = latch_reg;
  assign snreq   = snreq_reg;
  assign overrun = overrun_reg;
endmodule

// File: tb/tb_jtcop_snd_latch.sv
// Directed bench for the sound latch: latency, burst gap, overrun, long strobes,
// full FIFO with simultaneous push/pop, flush and reset.
module tb_jtcop_snd_latch;
  localparam int AW  = 2;
  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        main_we = 1'b0;
  logic [7:0]  main_din = 8'h00;
  logic        flush = 1'b0;
  logic        snd_rd = 1'b0;
  logic [7:0]  latch;
  logic        snreq;
  logic [AW:0] pending;
  logic        overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  jtcop_snd_latch #(.AW(AW), .GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .main_we  (main_we),
    .main_din (main_din),
    .flush    (flush),
    .snd_rd   (snd_rd),
    .latch    (latch),
    .snreq    (snreq),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_byte(input logic [7:0] b);
    main_we  = 1'b1;
    main_din = b;
    tick();
    main_we  = 1'b0;
    tick();
  endtask

  // Wait (bounded) for snreq high; a timeout counts as a failed check.
  task automatic wait_snreq(input string tag);
    int n;
    n = 0;
    while (snreq !== 1'b1 && n < 4 * GAP) begin
      tick();
      n++;
    end
    if (snreq !== 1'b1) check(tag, {31'd0, snreq}, 32'd1);
  endtask

  // Acknowledge the presented byte; if more is queued, verify the low gap length.
  task automatic ack_expect(input string tag, input logic [7:0] exp, input bit more);
    int low;
    check({tag, "_req"}, {31'd0, snreq}, 32'd1);
    check({tag, "_latch"}, {24'd0, latch}, {24'd0, exp});
    snd_rd = 1'b1;
    tick();
    check({tag, "_drop"}, {31'd0, snreq}, 32'd0);
    snd_rd = 1'b0;
    low = 1;
    while (snreq === 1'b0 && low < GAP + 8) begin
      tick();
      if (snreq === 1'b0) low++;
    end
    if (more) check({tag, "_gap"}, low, GAP);
    else      check({tag, "_idle"}, {31'd0, snreq}, 32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("rst_latch", {24'd0, latch}, 32'h00);
    check("rst_snreq", {31'd0, snreq}, 32'd0);
    check("rst_pending", {29'd0, pending}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single command: 5-cycle strobe, request 2 cycles after the edge
    main_we = 1'b1; main_din = 8'h3A;
    tick();
    check("t1_pend_e0", {29'd0, pending}, 32'd1);
    check("t1_snreq_e0", {31'd0, snreq}, 32'd0);
    tick();
    check("t1_snreq_e1", {31'd0, snreq}, 32'd1);
    check("t1_latch", {24'd0, latch}, 32'h3A);
    tick(); tick(); tick();
    main_we = 1'b0;
    check("t1_pend_hold", {29'd0, pending}, 32'd1);
    ack_expect("t1", 8'h3A, 1'b0);
    check("t1_pend_end", {29'd0, pending}, 32'd0);

    // Burst of three
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    check("t2_pend", {29'd0, pending}, 32'd3);
    ack_expect("t2a", 8'h11, 1'b1);
    ack_expect("t2b", 8'h22, 1'b1);
    ack_expect("t2c", 8'h33, 1'b0);
    check("t2_pend_end", {29'd0, pending}, 32'd0);

    // Overrun: five writes into a 4-deep FIFO
    write_byte(8'hA1); write_byte(8'hA2); write_byte(8'hA3);
    write_byte(8'hA4); write_byte(8'hA5);
    check("t3_pend", {29'd0, pending}, 32'd4);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    ack_expect("t3a", 8'hA1, 1'b1);
    ack_expect("t3b", 8'hA2, 1'b1);
    ack_expect("t3c", 8'hA3, 1'b1);
    ack_expect("t3d", 8'hA4, 1'b0);
    check("t3_pend_end", {29'd0, pending}, 32'd0);
    check("t3_ovr_sticky", {31'd0, overrun}, 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t3_ovr_flush", {31'd0, overrun}, 32'd0);

    // Long strobes
    main_we = 1'b1; main_din = 8'h5C;
    for (int i = 0; i < 100; i++) tick();
    main_we = 1'b0;
    tick();
    check("t4_one_push", {29'd0, pending}, 32'd1);
    write_byte(8'h6D);
    check("t4_pend2", {29'd0, pending}, 32'd2);
    check("t4_latch1", {24'd0, latch}, 32'h5C);
    snd_rd = 1'b1;
    tick();
    check("t4_ack1", {29'd0, pending}, 32'd1);
    for (int i = 0; i < GAP + 6; i++) tick();
    check("t4_req2", {31'd0, snreq}, 32'd1);
    check("t4_latch2", {24'd0, latch}, 32'h6D);
    check("t4_no_ack", {29'd0, pending}, 32'd1);
    snd_rd = 1'b0; tick();
    snd_rd = 1'b1; tick();
    check("t4_ack2_req", {31'd0, snreq}, 32'd0);
    check("t4_ack2_pend", {29'd0, pending}, 32'd0);
    snd_rd = 1'b0;
    for (int i = 0; i < GAP + 2; i++) tick();

    // Full FIFO with simultaneous push and pop
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03); write_byte(8'h04);
    check("t5_full", {29'd0, pending}, 32'd4);
    check("t5_latch", {24'd0, latch}, 32'h01);
    main_we = 1'b1; main_din = 8'h05; snd_rd = 1'b1;
    tick();
    main_we = 1'b0; snd_rd = 1'b0;
    check("t5_pend", {29'd0, pending}, 32'd4);
    check("t5_overrun", {31'd0, overrun}, 32'd0);
    wait_snreq("t5_wait_b");
    ack_expect("t5b", 8'h02, 1'b1);
    ack_expect("t5c", 8'h03, 1'b1);
    ack_expect("t5d", 8'h04, 1'b1);
    ack_expect("t5e", 8'h05, 1'b0);

    // Flush with three queued; a push in the flush cycle is discarded
    write_byte(8'h7A); write_byte(8'h7B); write_byte(8'h7C);
    check("t6_pend", {29'd0, pending}, 32'd3);
    flush = 1'b1; main_we = 1'b1; main_din = 8'hEE;
    tick();
    flush = 1'b0;
    check("t6_snreq", {31'd0, snreq}, 32'd0);
    check("t6_pend0", {29'd0, pending}, 32'd0);
    check("t6_latch", {24'd0, latch}, 32'h7A);
    tick(); main_we = 1'b0; tick(); tick();
    check("t6_no_push", {29'd0, pending}, 32'd0);
    check("t6_idle", {31'd0, snreq}, 32'd0);

    // Reset mid-request with overrun set
    write_byte(8'h81); write_byte(8'h82); write_byte(8'h83);
    write_byte(8'h84); write_byte(8'h85);
    check("t7_ovr", {31'd0, overrun}, 32'd1);
    check("t7_req", {31'd0, snreq}, 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t7_latch", {24'd0, latch}, 32'h00);
    check("t7_snreq", {31'd0, snreq}, 32'd0);
    check("t7_pending", {29'd0, pending}, 32'd0);
    check("t7_overrun", {31'd0, overrun}, 32'd0);
    tick(); tick();
    check("t7_stays", {31'd0, snreq}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
